// File: rtl/cnn_image_streamer.sv
// ---------------------------------------------------------------------------
// cnn_image_streamer
//
// Host-side transmitter for the CNN core's byte-stream input. On start it
// walks a synchronous pixel ROM, emitting each byte as a one-cycle tx_valid
// pulse. In training mode it then sends the latched label byte. Afterwards it
// waits for the CNN's ready strobe to capture the classification byte, or
// gives up after TIMEOUT cycles and raises a sticky timeout flag.
//
// Parameters:
//   IMAGE_PIXELS  pixel bytes per image (>= 1)
//   ADDR_W        ROM address width, 2**ADDR_W >= IMAGE_PIXELS
//   GAP_CYCLES    idle cycles inserted after every tx_valid pulse
//   TIMEOUT       max cycles spent waiting for the result (>= 1)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a transfer (accepted only when idle)
//   abort             cancel the transfer in progress
//   mode_train        latched at start, 1 = append label byte
//   label_in          label byte, latched at start
//   rom_en/rom_addr   ROM read strobe and address
//   rom_data          ROM data, valid the cycle after rom_en
//   tx_data/tx_valid  byte and strobe towards the CNN input
//   rx_data/rx_ready  classification byte and strobe from the CNN
//   result            last captured classification byte
//   busy              high whenever a transfer is in progress
//   done              one-cycle pulse at end of transfer
//   timeout_err       sticky timeout flag, cleared by the next start
// ---------------------------------------------------------------------------
module cnn_image_streamer #(
    parameter int IMAGE_PIXELS = 784,
    parameter int ADDR_W       = 10,
    parameter int GAP_CYCLES   = 0,
    parameter int TIMEOUT      = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode_train,
    input  logic [7:0]        label_in,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        result,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_LABEL,
        S_WAIT_RES
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              mode_q, mode_d;
    logic [7:0]        label_q, label_d;
    logic              label_sent_q, label_sent_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              advance;

    // Next-state and datapath logic. "advance" marks the end of a byte slot
    // (SEND, or the last GAP cycle) where we pick the next pixel, the label,
    // or move on to waiting for the result.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_cnt_d     = gap_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        mode_d        = mode_q;
        label_d       = label_q;
        label_sent_d  = label_sent_q;
        tx_data_d     = tx_data_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        done_d        = 1'b0;
        advance       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high during the done pulse; a start there
                // belongs to the finishing frame and is ignored
                if (start && !busy_q) begin
                    state_d       = S_FETCH;
                    mode_d        = mode_train;
                    label_d       = label_in;
                    idx_d         = '0;
                    label_sent_d  = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // the label reuses LOAD so its slot has the same length as a pixel
                tx_data_d = label_sent_q ? label_q : rom_data;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_LABEL: begin
                state_d = S_LOAD;
            end
            S_WAIT_RES: begin
                // ready wins over a simultaneous timeout expiry
                if (rx_ready) begin
                    result_d = rx_data;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q < LAST_IDX) begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = S_FETCH;
            end else if (mode_q && !label_sent_q) begin
                label_sent_d = 1'b1;
                state_d      = S_LABEL;
            end else begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_RES;
            end
        end

        // abort overrides everything, including a pending SEND or result capture
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            result_d      = result_q;
            timeout_err_d = timeout_err_q;
            done_d        = 1'b0;
        end

        tx_valid_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            gap_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            mode_q        <= 1'b0;
            label_q       <= '0;
            label_sent_q  <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_cnt_q     <= gap_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mode_q        <= mode_d;
            label_q       <= label_d;
            label_sent_q  <= label_sent_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            result_q      <= result_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rom_en      = (state_q == S_FETCH);
    assign rom_addr    = idx_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign result      = result_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cnn_image_streamer.sv
// ---------------------------------------------------------------------------
// tb_cnn_image_streamer
//
// Two instances of the streamer: dut A (4 pixels, no gap, timeout 8) and
// dut B (4 pixels, gap 2, timeout 8). Each has its own start and a small ROM
// holding {11,22,33,44}; the remaining inputs are shared because only the
// started instance reacts to them. Expected tx bytes and their cycle numbers
// are queued when a frame is launched and popped as tx_valid pulses appear.
// Cycle k is the k-th cycle after the edge that samples start; outputs are
// sampled and inputs driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_cnn_image_streamer;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       abort = 1'b0;
    logic       mode_train = 1'b0;
    logic [7:0] label_in = 8'h00;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;

    logic       a_rom_en, b_rom_en;
    logic [9:0] a_rom_addr, b_rom_addr;
    logic [7:0] a_rom_data, b_rom_data;
    logic [7:0] a_tx_data, b_tx_data;
    logic       a_tx_valid, b_tx_valid;
    logic [7:0] a_result, b_result;
    logic       a_busy, b_busy;
    logic       a_done, b_done;
    logic       a_timeout_err, b_timeout_err;

    logic [7:0] rom [0:3];

    always #5 clk = ~clk;

    initial begin
        rom[0] = 8'd11;
        rom[1] = 8'd22;
        rom[2] = 8'd33;
        rom[3] = 8'd44;
    end

    always_ff @(posedge clk) begin
        if (a_rom_en) a_rom_data <= rom[a_rom_addr[1:0]];
        if (b_rom_en) b_rom_data <= rom[b_rom_addr[1:0]];
    end

    cnn_image_streamer #(.IMAGE_PIXELS(4), .ADDR_W(10), .GAP_CYCLES(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .mode_train(mode_train),
        .label_in(label_in), .rom_en(a_rom_en), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .result(a_result), .busy(a_busy), .done(a_done), .timeout_err(a_timeout_err)
    );

    cnn_image_streamer #(.IMAGE_PIXELS(4), .ADDR_W(10), .GAP_CYCLES(2), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .mode_train(mode_train),
        .label_in(label_in), .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .result(b_result), .busy(b_busy), .done(b_done), .timeout_err(b_timeout_err)
    );

    // Queue the four pixel pulses of dut A, spaced 3 cycles apart from cycle 3.
    task automatic push_pixels_a();
        exp_q.delete();
        exp_q.push_back('{8'd11, 3});
        exp_q.push_back('{8'd22, 6});
        exp_q.push_back('{8'd33, 9});
        exp_q.push_back('{8'd44, 12});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_rom_en, a_rom_addr, a_tx_data, a_tx_valid, a_result, a_busy, a_done, a_timeout_err} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_a: outputs=%h required 0",
                     {a_rom_en, a_rom_addr, a_tx_data, a_tx_valid, a_result, a_busy, a_done, a_timeout_err});
        end
        n_cmp++;
        if ({b_rom_en, b_rom_addr, b_tx_data, b_tx_valid, b_result, b_busy, b_done, b_timeout_err} !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_b: outputs=%h required 0",
                     {b_rom_en, b_rom_addr, b_tx_data, b_tx_valid, b_result, b_busy, b_done, b_timeout_err});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_inference();
        exp_t e;
        int   dones = 0;
        push_pixels_a();
        mode_train = 1'b0;
        label_in   = 8'hAA;
        rx_data    = 8'd7;
        start_a    = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start_a  = 1'b0;
            rx_ready = 1'b0;
            if (a_tx_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL inf_pulse: extra pulse data=%0d cycle=%0d required none", a_tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (a_tx_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("[TB] FAIL inf_pulse: data=%0d cycle=%0d required data=%0d cycle=%0d",
                                 a_tx_data, cyc, e.data, e.cyc);
                    end
                end
            end
            if (a_done) begin
                dones++;
                n_cmp++;
                if (cyc != 18 || a_result !== 8'd7 || a_timeout_err !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL inf_done: cycle=%0d result=%0d err=%b required cycle=18 result=7 err=0",
                             cyc, a_result, a_timeout_err);
                end
            end
            if (cyc == 1) begin
                n_cmp++;
                if (a_busy !== 1'b1 || a_rom_en !== 1'b1 || a_rom_addr !== 10'd0) begin
                    n_err++;
                    $display("[TB] FAIL inf_fetch0: busy=%b rom_en=%b addr=%0d required 1 1 0",
                             a_busy, a_rom_en, a_rom_addr);
                end
            end
            if (cyc == 19) begin
                n_cmp++;
                if (a_busy !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL inf_busy_fall: busy=%b required 0", a_busy);
                end
            end
            if (cyc == 17) rx_ready = 1'b1;
        end
        n_cmp++;
        if (dones != 1 || exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL inf_counts: dones=%0d leftover=%0d required 1 0", dones, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int dones = 0;
        int pulses = 0;
        push_pixels_a();
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (a_tx_valid) begin
                pulses++;
                void'(exp_q.pop_front());
            end
            if (a_done) begin
                dones++;
                n_cmp++;
                if (cyc != 21 || a_timeout_err !== 1'b1 || a_result !== 8'd7) begin
                    n_err++;
                    $display("[TB] FAIL tmo_done: cycle=%0d err=%b result=%0d required cycle=21 err=1 result=7",
                             cyc, a_timeout_err, a_result);
                end
            end
            if (cyc == 20) begin
                n_cmp++;
                if (a_timeout_err !== 1'b0 || a_busy !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL tmo_early: err=%b busy=%b required 0 1", a_timeout_err, a_busy);
                end
            end
            if (cyc == 24) begin
                n_cmp++;
                if (a_timeout_err !== 1'b1 || a_busy !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL tmo_sticky: err=%b busy=%b required 1 0", a_timeout_err, a_busy);
                end
            end
        end
        n_cmp++;
        if (dones != 1 || pulses != 4) begin
            n_err++;
            $display("[TB] FAIL tmo_counts: dones=%0d pulses=%0d required 1 4", dones, pulses);
        end
    endtask

    task automatic test_rx_ready_races();
        int dones = 0;
        push_pixels_a();
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            start_a  = 1'b0;
            rx_ready = 1'b0;
            if (cyc == 1) begin
                n_cmp++;
                if (a_timeout_err !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL race_err_clear: err=%b required 0", a_timeout_err);
                end
            end
            if (cyc == 10) begin
                n_cmp++;
                if (a_result !== 8'd7 || a_done !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL race_early_ready: result=%0d done=%b required 7 0", a_result, a_done);
                end
            end
            if (a_done) begin
                dones++;
                n_cmp++;
                if (cyc != 21 || a_result !== 8'd55 || a_timeout_err !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL race_expiry: cycle=%0d result=%0d err=%b required cycle=21 result=55 err=0",
                             cyc, a_result, a_timeout_err);
                end
            end
            if (cyc == 5) begin
                rx_ready = 1'b1;
                rx_data  = 8'd99;
            end
            if (cyc == 20) begin
                rx_ready = 1'b1;
                rx_data  = 8'd55;
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("[TB] FAIL race_dones: dones=%0d required 1", dones);
        end
    endtask

    task automatic test_training();
        exp_t e;
        int   dones = 0;
        int   fetches = 0;
        exp_q.delete();
        exp_q.push_back('{8'd11, 3});
        exp_q.push_back('{8'd22, 8});
        exp_q.push_back('{8'd33, 13});
        exp_q.push_back('{8'd44, 18});
        exp_q.push_back('{8'd5, 23});
        mode_train = 1'b1;
        label_in   = 8'd5;
        rx_data    = 8'd3;
        start_b    = 1'b1;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(negedge clk);
            start_b  = 1'b0;
            rx_ready = 1'b0;
            if (b_rom_en) begin
                n_cmp++;
                if (b_rom_addr !== 10'(fetches)) begin
                    n_err++;
                    $display("[TB] FAIL train_addr: addr=%0d required %0d", b_rom_addr, fetches);
                end
                fetches++;
            end
            if (b_tx_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL train_pulse: extra pulse data=%0d cycle=%0d required none", b_tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (b_tx_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("[TB] FAIL train_pulse: data=%0d cycle=%0d required data=%0d cycle=%0d",
                                 b_tx_data, cyc, e.data, e.cyc);
                    end
                end
            end
            if (b_done) begin
                dones++;
                n_cmp++;
                if (cyc != 29 || b_result !== 8'd3 || b_timeout_err !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL train_done: cycle=%0d result=%0d err=%b required cycle=29 result=3 err=0",
                             cyc, b_result, b_timeout_err);
                end
            end
            if (cyc == 10) begin
                label_in   = 8'd9;
                mode_train = 1'b0;
            end
            if (cyc == 28) rx_ready = 1'b1;
        end
        n_cmp++;
        if (dones != 1 || fetches != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL train_counts: dones=%0d fetches=%0d leftover=%0d required 1 4 0",
                     dones, fetches, exp_q.size());
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   dones = 0;
        int   late_busy = 0;
        exp_q.delete();
        exp_q.push_back('{8'd11, 3});
        exp_q.push_back('{8'd22, 6});
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort   = 1'b0;
            if (a_tx_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL abort_pulse: extra pulse data=%0d cycle=%0d required none", a_tx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (a_tx_data !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("[TB] FAIL abort_pulse: data=%0d cycle=%0d required data=%0d cycle=%0d",
                                 a_tx_data, cyc, e.data, e.cyc);
                    end
                end
            end
            if (a_done) dones++;
            if (cyc >= 9 && a_busy) late_busy++;
            if (cyc == 9) begin
                n_cmp++;
                if (a_busy !== 1'b0 || a_tx_valid !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL abort_idle: busy=%b tx_valid=%b required 0 0", a_busy, a_tx_valid);
                end
            end
            if (cyc == 4) start_a = 1'b1;
            if (cyc == 8) abort = 1'b1;
        end
        n_cmp++;
        if (dones != 0 || late_busy != 0 || exp_q.size() != 0 || a_result !== 8'd55 || a_timeout_err !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_after: dones=%0d late_busy=%0d leftover=%0d result=%0d err=%b required 0 0 0 55 0",
                     dones, late_busy, exp_q.size(), a_result, a_timeout_err);
        end
    endtask

    task automatic test_reset_midwait();
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        n_cmp++;
        if (a_busy !== 1'b1 || a_result !== 8'd55 || a_tx_data !== 8'd44) begin
            n_err++;
            $display("[TB] FAIL rst_pre: busy=%b result=%0d tx_data=%0d required 1 55 44", a_busy, a_result, a_tx_data);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_rom_en, a_rom_addr, a_tx_data, a_tx_valid, a_result, a_busy, a_done, a_timeout_err} !== '0) begin
            n_err++;
            $display("[TB] FAIL rst_async: outputs=%h required 0",
                     {a_rom_en, a_rom_addr, a_tx_data, a_tx_valid, a_result, a_busy, a_done, a_timeout_err});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            n_cmp++;
            if (a_tx_valid !== (cyc == 3) || (cyc == 3 && a_tx_data !== 8'd11)) begin
                n_err++;
                $display("[TB] FAIL rst_restart: cycle=%0d tx_valid=%b data=%0d required valid only in cycle 3 with 11",
                         cyc, a_tx_valid, a_tx_data);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inference();
        test_timeout();
        test_rx_ready_races();
        test_training();
        test_abort();
        test_reset_midwait();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
